// File: rtl/decode_issue.sv
// RV32I decode/issue: one-cycle registered output aligned with RF read data.
// Scoreboard stalls RAW/WAW hazards; input blocked by hazard, flush or a full output slot.
module decode_issue #(
    parameter bit CHECK_WAW = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        in_ready,
    output logic [4:0]  rf_ra1,
    output logic [4:0]  rf_ra2,
    output logic        rf_re1,
    output logic        rf_re2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_funct3,
    output logic        out_funct7b5,
    output logic [4:0]  out_rd,
    output logic        out_wr,
    output logic [31:0] out_imm,
    output logic        out_illegal,
    input  logic        wb_we,
    input  logic [4:0]  wb_wa,
    input  logic        flush
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [31:0] r_sb;
    logic        r_out_valid;
    logic [31:0] r_out_pc;
    logic [6:0]  r_out_opcode;
    logic [2:0]  r_out_funct3;
    logic        r_out_funct7b5;
    logic [4:0]  r_out_rd;
    logic        r_out_wr;
    logic [31:0] r_out_imm;
    logic        r_out_illegal;

    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic        w_legal;
    logic        w_uses1;
    logic        w_uses2;
    logic        w_wr_cls;
    logic        w_wr;
    logic [31:0] w_imm;
    logic        w_hz;
    logic        w_slot;
    logic        w_accept;
    logic [31:0] w_set;
    logic [31:0] w_clr;

    assign w_rs1 = in_instr[19:15];
    assign w_rs2 = in_instr[24:20];
    assign w_rd  = in_instr[11:7];

    // The full 7-bit match also rejects instr[1:0] != 2'b11.
    always_comb begin
        w_legal  = 1'b0;
        w_uses1  = 1'b0;
        w_uses2  = 1'b0;
        w_wr_cls = 1'b0;
        w_imm    = '0;
        case (in_instr[6:0])
            OP_LUI, OP_AUIPC: begin
                w_legal  = 1'b1;
                w_wr_cls = 1'b1;
                w_imm    = {in_instr[31:12], 12'h000};
            end
            OP_JAL: begin
                w_legal  = 1'b1;
                w_wr_cls = 1'b1;
                w_imm    = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                            in_instr[30:21], 1'b0};
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                w_legal  = 1'b1;
                w_uses1  = 1'b1;
                w_wr_cls = 1'b1;
                w_imm    = {{21{in_instr[31]}}, in_instr[30:20]};
            end
            OP_BRANCH: begin
                w_legal = 1'b1;
                w_uses1 = 1'b1;
                w_uses2 = 1'b1;
                w_imm   = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0};
            end
            OP_STORE: begin
                w_legal = 1'b1;
                w_uses1 = 1'b1;
                w_uses2 = 1'b1;
                w_imm   = {{21{in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
            end
            OP_REG: begin
                w_legal  = 1'b1;
                w_uses1  = 1'b1;
                w_uses2  = 1'b1;
                w_wr_cls = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: begin
                w_legal = 1'b1;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    assign w_wr = w_wr_cls & (w_rd != 5'd0);

    // Hazard looks only at the registered scoreboard; same-edge writeback is safe next cycle.
    assign w_hz = (r_sb[w_rs1] & w_uses1) | (r_sb[w_rs2] & w_uses2)
                | (CHECK_WAW & r_sb[w_rd] & w_wr);

    assign w_slot   = ~r_out_valid | out_ready;
    assign in_ready = resetn & ~w_hz & ~flush & w_slot;
    assign w_accept = in_valid & in_ready;

    assign rf_ra1 = w_rs1;
    assign rf_ra2 = w_rs2;
    assign rf_re1 = w_accept & w_uses1;
    assign rf_re2 = w_accept & w_uses2;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_accept & w_wr) begin
            w_set[w_rd] = 1'b1;
        end
        if (wb_we & (wb_wa != 5'd0)) begin
            w_clr[wb_wa] = 1'b1;
        end
        if (flush & r_out_valid & r_out_wr) begin
            w_clr[r_out_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sb <= '0;
        end else begin
            r_sb <= ((r_sb & ~w_clr) | w_set) & ~32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_valid    <= 1'b0;
            r_out_pc       <= '0;
            r_out_opcode   <= '0;
            r_out_funct3   <= '0;
            r_out_funct7b5 <= 1'b0;
            r_out_rd       <= '0;
            r_out_wr       <= 1'b0;
            r_out_imm      <= '0;
            r_out_illegal  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid    <= 1'b1;
            r_out_pc       <= in_pc;
            r_out_opcode   <= in_instr[6:0];
            r_out_funct3   <= in_instr[14:12];
            r_out_funct7b5 <= in_instr[30];
            r_out_rd       <= w_rd;
            r_out_wr       <= w_wr;
            r_out_imm      <= w_imm;
            r_out_illegal  <= ~w_legal;
        end else if (out_ready | flush) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_pc       = r_out_pc;
    assign out_opcode   = r_out_opcode;
    assign out_funct3   = r_out_funct3;
    assign out_funct7b5 = r_out_funct7b5;
    assign out_rd       = r_out_rd;
    assign out_wr       = r_out_wr;
    assign out_imm      = r_out_imm;
    assign out_illegal  = r_out_illegal;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: decode vector table, hazard/stall/flush/reset sequences,
// and a long random run against an instruction-level reference model.
module tb_decode_issue;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;
    logic [4:0]  rf_ra1;
    logic [4:0]  rf_ra2;
    logic        rf_re1;
    logic        rf_re2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic        out_funct7b5;
    logic [4:0]  out_rd;
    logic        out_wr;
    logic [31:0] out_imm;
    logic        out_illegal;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic        flush;

    decode_issue #(.CHECK_WAW(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_re1(rf_re1), .rf_re2(rf_re2),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
        .out_rd(out_rd), .out_wr(out_wr), .out_imm(out_imm), .out_illegal(out_illegal),
        .wb_we(wb_we), .wb_wa(wb_wa), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd, input logic [6:0] op);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input logic [6:0] op);
        logic [31:0] im;
        im = imm;
        return {im[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1,
                                          input int f3, input logic [6:0] op);
        logic [31:0] im;
        im = imm;
        return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], op};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                          input int f3, input logic [6:0] op);
        logic [31:0] im;
        im = imm;
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], op};
    endfunction
    function automatic logic [31:0] enc_u(input logic [31:0] im, input int rd,
                                          input logic [6:0] op);
        return {im[31:12], 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd, input logic [6:0] op);
        logic [31:0] im;
        im = imm;
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), op};
    endfunction

    // ---------------- reference decode ----------------
    typedef struct packed {
        logic        legal;
        logic        u1;
        logic        u2;
        logic        wcls;
        logic        wr;
        logic [31:0] imm;
    } dec_t;

    function automatic dec_t ref_dec(input logic [31:0] ins);
        dec_t d;
        int   neg;
        d = '0;
        neg = ins[31] ? 1 : 0;
        case (ins[6:0])
            7'h37, 7'h17: begin
                d.legal = 1; d.wcls = 1;
                d.imm = ins & 32'hFFFF_F000;
            end
            7'h6F: begin
                d.legal = 1; d.wcls = 1;
                d.imm = -neg * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                        + int'(ins[30:21]) * 2;
            end
            7'h67, 7'h03, 7'h13: begin
                d.legal = 1; d.u1 = 1; d.wcls = 1;
                d.imm = -neg * 2048 + int'(ins[30:20]);
            end
            7'h63: begin
                d.legal = 1; d.u1 = 1; d.u2 = 1;
                d.imm = -neg * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                        + int'(ins[11:8]) * 2;
            end
            7'h23: begin
                d.legal = 1; d.u1 = 1; d.u2 = 1;
                d.imm = -neg * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:7]);
            end
            7'h33: begin
                d.legal = 1; d.u1 = 1; d.u2 = 1; d.wcls = 1;
            end
            7'h0F, 7'h73: d.legal = 1;
            default: d.legal = 0;
        endcase
        d.wr = d.wcls && (ins[11:7] != 5'd0);
        return d;
    endfunction

    // ---------------- drive helpers ----------------
    task automatic drv(input logic v, input logic [31:0] ins, input logic ord,
                       input logic fl, input logic we, input logic [4:0] wa);
        in_valid  = v;
        in_instr  = ins;
        out_ready = ord;
        flush     = fl;
        wb_we     = we;
        wb_wa     = wa;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drv(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wr;
        logic        ill;
        logic        re1;
        logic        re2;
    } tv_t;

    tv_t tv[15];
    tv_t t;

    // ---------------- random model state ----------------
    bit          m_sb[32];
    logic        m_ov;
    logic [31:0] m_pc, m_imm;
    logic [6:0]  m_opc;
    logic [2:0]  m_f3;
    logic        m_f7, m_wr, m_ill;
    logic [4:0]  m_rd;
    dec_t        d;
    logic        hz, e_rdy, acc, held;
    logic [31:0] r_ins;
    logic [6:0]  ops[13] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                             7'h13, 7'h33, 7'h0F, 7'h73, 7'h00, 7'h12};

    function automatic logic [31:0] rnd_instr();
        logic [31:0] v;
        v = $urandom;
        v[6:0]   = ops[$urandom_range(0, 12)];
        v[11:7]  = 5'($urandom_range(0, 7));
        v[19:15] = 5'($urandom_range(0, 7));
        v[24:20] = 5'($urandom_range(0, 7));
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        in_pc  = 32'h0000_1000;
        drv(1'b1, enc_i(5, 0, 0, 1, 7'h13), 1'b1, 1'b0, 1'b0, 5'd0);
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_re", {rf_re1, rf_re2}, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_fields", {out_opcode, out_funct3, out_funct7b5, out_rd, out_wr, out_illegal}, 0);

        tv[0]  = '{enc_u(32'hABCDE000, 5, 7'h37), 32'h100, 32'hABCDE000, 5'd5, 1, 0, 0, 0};
        tv[1]  = '{enc_s(-4, 2, 1, 2, 7'h23), 32'h104, 32'hFFFFFFFC, 5'd28, 0, 0, 1, 1};
        tv[2]  = '{enc_b(-8, 4, 3, 0, 7'h63), 32'h108, 32'hFFFFFFF8, 5'd25, 0, 0, 1, 1};
        tv[3]  = '{enc_j(2048, 1, 7'h6F), 32'h10C, 32'h00000800, 5'd1, 1, 0, 0, 0};
        tv[4]  = '{enc_j(-4, 0, 7'h6F), 32'h110, 32'hFFFFFFFC, 5'd0, 0, 0, 0, 0};
        tv[5]  = '{enc_i(12, 2, 0, 1, 7'h67), 32'h114, 32'h0000000C, 5'd1, 1, 0, 1, 0};
        tv[6]  = '{enc_i(-1, 8, 2, 7, 7'h03), 32'h118, 32'hFFFFFFFF, 5'd7, 1, 0, 1, 0};
        tv[7]  = '{enc_i(0, 0, 0, 0, 7'h13), 32'h11C, 32'h0, 5'd0, 0, 0, 1, 0};
        tv[8]  = '{enc_r(32, 8, 7, 0, 6, 7'h33), 32'h120, 32'h0, 5'd6, 1, 0, 1, 1};
        tv[9]  = '{enc_u(32'h80000000, 3, 7'h17), 32'h124, 32'h80000000, 5'd3, 1, 0, 0, 0};
        tv[10] = '{32'h00000000, 32'h128, 32'h0, 5'd0, 0, 1, 0, 0};
        tv[11] = '{enc_i(7, 1, 0, 5, 7'h12), 32'h12C, 32'h0, 5'd5, 0, 1, 0, 0};
        tv[12] = '{enc_i(255, 0, 0, 0, 7'h0F), 32'h130, 32'h0, 5'd0, 0, 0, 0, 0};
        tv[13] = '{32'h00000073, 32'h134, 32'h0, 5'd0, 0, 0, 0, 0};
        tv[14] = '{enc_i(-2048, 1, 0, 5, 7'h13), 32'h138, 32'hFFFFF800, 5'd5, 1, 0, 1, 0};

        for (int i = 0; i < 15; i++) begin
            t = tv[i];
            do_reset();
            drv(1'b1, t.ins, 1'b1, 1'b0, 1'b0, 5'd0);
            in_pc = t.pc;
            #1;
            chk($sformatf("tv%0d_rdy", i), in_ready, 1);
            chk($sformatf("tv%0d_re", i), {rf_re1, rf_re2}, {t.re1, t.re2});
            chk($sformatf("tv%0d_ra", i), {rf_ra1, rf_ra2}, {t.ins[19:15], t.ins[24:20]});
            @(negedge clk);
            drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
            #1;
            chk($sformatf("tv%0d_ov", i), out_valid, 1);
            chk($sformatf("tv%0d_pc", i), out_pc, t.pc);
            chk($sformatf("tv%0d_imm", i), out_imm, t.imm);
            chk($sformatf("tv%0d_rd", i), out_rd, t.rd);
            chk($sformatf("tv%0d_wr_ill", i), {out_wr, out_illegal}, {t.wr, t.ill});
            chk($sformatf("tv%0d_op", i), {out_opcode, out_funct3, out_funct7b5},
                {t.ins[6:0], t.ins[14:12], t.ins[30]});
        end
        in_pc = 32'h0000_1000;

        // back-to-back RAW on x1, released by writeback of x1
        do_reset();
        drv(1'b1, enc_i(5, 0, 0, 1, 7'h13), 1'b1, 1'b0, 1'b0, 5'd0);
        #1 chk("b2b_first_rdy", in_ready, 1);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            drv(1'b1, enc_r(0, 1, 1, 0, 2, 7'h33), 1'b1, 1'b0, 1'b0, 5'd0);
            #1;
            chk("b2b_hold_rdy", in_ready, 0);
            chk("b2b_hold_re1", rf_re1, 0);
            @(negedge clk);
        end
        drv(1'b1, enc_r(0, 1, 1, 0, 2, 7'h33), 1'b1, 1'b0, 1'b1, 5'd1);
        #1 chk("b2b_wb_cycle_rdy", in_ready, 0);
        @(negedge clk);
        drv(1'b1, enc_r(0, 1, 1, 0, 2, 7'h33), 1'b1, 1'b0, 1'b0, 5'd0);
        #1;
        chk("b2b_issue_rdy", in_ready, 1);
        chk("b2b_issue_re", {rf_re1, rf_re2}, 2'b11);
        chk("b2b_issue_ra", {rf_ra1, rf_ra2}, {5'd1, 5'd1});
        @(negedge clk);
        drv(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
        #1 chk("b2b_out_rd", {out_valid, out_rd}, {1'b1, 5'd2});

        // same-cycle writeback of x3 permits issue only the next cycle
        do_reset();
        drv(1'b1, enc_i(1, 0, 0, 3, 7'h13), 1'b1, 1'b0, 1'b0, 5'd0);
        #1;
        @(negedge clk);
        drv(1'b1, enc_r(0, 0, 3, 0, 4, 7'h33), 1'b1, 1'b0, 1'b1, 5'd3);
        #1;
        chk("wbN_rdy", in_ready, 0);
        chk("wbN_re", {rf_re1, rf_re2}, 2'b00);
        @(negedge clk);
        drv(1'b1, enc_r(0, 0, 3, 0, 4, 7'h33), 1'b1, 1'b0, 1'b0, 5'd0);
        #1;
        chk("wbN1_rdy", in_ready, 1);
        chk("wbN1_re", {rf_re1, rf_re2}, 2'b11);
        @(negedge clk);

        // output stall: sub x6,x7,x8 held three cycles
        do_reset();
        drv(1'b1, enc_r(32, 8, 7, 0, 6, 7'h33), 1'b1, 1'b0, 1'b0, 5'd0);
        #1 chk("stall_issue_re", {rf_re1, rf_re2}, 2'b11);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            drv(1'b1, enc_i(1, 0, 0, 10, 7'h13), 1'b0, 1'b0, 1'b0, 5'd0);
            #1;
            chk("stall_ov", out_valid, 1);
            chk("stall_rdy", in_ready, 0);
            chk("stall_re", {rf_re1, rf_re2}, 2'b00);
            chk("stall_fields", {out_opcode, out_funct7b5, out_rd, out_wr}, {7'h33, 1'b1, 5'd6, 1'b1});
            @(negedge clk);
        end
        drv(1'b1, enc_i(1, 0, 0, 10, 7'h13), 1'b1, 1'b0, 1'b0, 5'd0);
        #1;
        chk("stall_resume_rdy", in_ready, 1);
        chk("stall_resume_re1", rf_re1, 1);
        @(negedge clk);
        drv(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
        #1 chk("stall_next_rd", {out_valid, out_rd}, {1'b1, 5'd10});

        // flush of presented addi x9 drops it and frees x9
        do_reset();
        drv(1'b1, enc_i(1, 0, 0, 9, 7'h13), 1'b1, 1'b0, 1'b0, 5'd0);
        #1;
        @(negedge clk);
        drv(1'b1, enc_r(0, 0, 9, 0, 11, 7'h33), 1'b0, 1'b1, 1'b0, 5'd0);
        #1;
        chk("flush_cycle_ov", out_valid, 1);
        chk("flush_cycle_rdy", in_ready, 0);
        chk("flush_cycle_re", {rf_re1, rf_re2}, 2'b00);
        @(negedge clk);
        drv(1'b1, enc_r(0, 0, 9, 0, 11, 7'h33), 1'b1, 1'b0, 1'b0, 5'd0);
        #1;
        chk("flush_drop_ov", out_valid, 0);
        chk("flush_sb_clear_rdy", in_ready, 1);
        @(negedge clk);
        drv(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
        #1 chk("flush_after_rd", {out_valid, out_rd}, {1'b1, 5'd11});

        // asynchronous reset mid-stream
        do_reset();
        drv(1'b1, enc_i(1, 0, 0, 5, 7'h13), 1'b0, 1'b0, 1'b0, 5'd0);
        #1 chk("rstm_acc_rdy", in_ready, 1);
        @(negedge clk);
        drv(1'b1, enc_r(0, 5, 5, 0, 6, 7'h33), 1'b0, 1'b0, 1'b0, 5'd0);
        #1;
        chk("rstm_pre_ov", out_valid, 1);
        chk("rstm_pre_hz", in_ready, 0);
        #2 resetn = 1'b0;
        #1;
        chk("rstm_ov", out_valid, 0);
        chk("rstm_rdy_re", {in_ready, rf_re1, rf_re2}, 3'b000);
        chk("rstm_fields", {out_rd, out_wr, out_imm}, 0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rstm_post_rdy", in_ready, 1);
        chk("rstm_post_re", {rf_re1, rf_re2}, 2'b11);
        @(negedge clk);
        drv(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
        #1 chk("rstm_post_out", {out_valid, out_rd}, {1'b1, 5'd6});

        // random run against the reference model
        do_reset();
        foreach (m_sb[i]) m_sb[i] = 1'b0;
        m_ov = 0; m_pc = 0; m_imm = 0; m_opc = 0; m_f3 = 0; m_f7 = 0; m_wr = 0; m_ill = 0; m_rd = 0;
        held  = 0;
        r_ins = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            if (!held) begin
                r_ins    = rnd_instr();
                in_valid = ($urandom_range(0, 3) != 0);
                in_pc    = $urandom;
            end
            in_instr  = r_ins;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            wb_we     = ($urandom_range(0, 2) == 0);
            wb_wa     = 5'($urandom_range(0, 7));
            #1;
            d     = ref_dec(r_ins);
            hz    = (d.u1 && m_sb[r_ins[19:15]]) || (d.u2 && m_sb[r_ins[24:20]])
                 || (d.wr && m_sb[r_ins[11:7]]);
            e_rdy = !hz && !flush && (!m_ov || out_ready);
            acc   = in_valid && e_rdy;
            chk("rnd_rdy", in_ready, e_rdy);
            chk("rnd_re", {rf_re1, rf_re2}, {acc && d.u1, acc && d.u2});
            chk("rnd_ra", {rf_ra1, rf_ra2}, {r_ins[19:15], r_ins[24:20]});
            chk("rnd_ov", out_valid, m_ov);
            chk("rnd_pc", out_pc, m_pc);
            chk("rnd_imm", out_imm, m_imm);
            chk("rnd_fields", {out_opcode, out_funct3, out_funct7b5, out_rd, out_wr, out_illegal},
                {m_opc, m_f3, m_f7, m_rd, m_wr, m_ill});
            // scoreboard: clears first, then the issue's set so it wins on collision
            if (wb_we && wb_wa != 0) m_sb[wb_wa] = 1'b0;
            if (flush && m_ov && m_wr) m_sb[m_rd] = 1'b0;
            if (acc && d.wr) m_sb[r_ins[11:7]] = 1'b1;
            if (acc) begin
                m_ov = 1; m_pc = in_pc; m_imm = d.imm; m_opc = r_ins[6:0];
                m_f3 = r_ins[14:12]; m_f7 = r_ins[30]; m_rd = r_ins[11:7];
                m_wr = d.wr; m_ill = !d.legal;
            end else if (out_ready || flush) begin
                m_ov = 0;
            end
            held = in_valid && !acc;
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- RV32I decode/issue stage that sits directly upstream of the two-read-port register file.
- Accepts fetched instructions over a valid/ready handshake and drives the register-file read addresses and read enables.
- Tracks in-flight destination registers in a 32-bit scoreboard and stalls on RAW/WAW hazards.
- Presents decoded fields to execute in the same cycle the register-file read data becomes valid.

Parameters:
- CHECK_WAW, 1, when 1 stall issue while the instruction's own rd is pending; when 0 check only rs1/rs2.

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous reset, active-low
- in_valid  in  1  fetch presents an instruction
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- in_ready  out  1  decode accepts in_instr this cycle
- rf_ra1  out  5  register-file read address 1 = in_instr[19:15]
- rf_ra2  out  5  register-file read address 2 = in_instr[24:20]
- rf_re1  out  1  register-file read enable 1
- rf_re2  out  1  register-file read enable 2
- out_valid  out  1  decoded instruction presented; register-file dout1/dout2 valid
- out_ready  in  1  execute consumes the presented instruction
- out_pc  out  32  pc of the presented instruction
- out_opcode  out  7  instr[6:0]
- out_funct3  out  3  instr[14:12]
- out_funct7b5  out  1  instr[30]
- out_rd  out  5  destination register
- out_wr  out  1  instruction writes rd (rd != 0)
- out_imm  out  32  sign-extended immediate
- out_illegal  out  1  opcode not in RV32I base set
- wb_we  in  1  writeback is writing the register file this cycle
- wb_wa  in  5  writeback register address
- flush  in  1  discard the presented instruction and refuse input this cycle

Behaviour:
- Reset (resetn low, asynchronous): out_valid=0, scoreboard=0, and all out_* registers = 0. rf_re1, rf_re2 and in_ready read 0 while resetn is low.
- Hazard flag: hz = (sb[rs1] & uses_rs1) | (sb[rs2] & uses_rs2) | (CHECK_WAW & sb[rd] & writes_rd). uses_*/writes_rd come from the opcode class; x0 is never pending.
- Accept condition: accept = in_valid & ~hz & ~flush & (~out_valid | out_ready). in_ready = ~hz & ~flush & (~out_valid | out_ready).
- Read enables and addresses: rf_re1 = accept & uses_rs1 and rf_re2 = accept & uses_rs2 (combinational). rf_ra1/rf_ra2 are always the raw instruction fields.
- Read latency: register-file data appears one cycle after accept, aligned with out_valid. Read enables are 0 when no accept occurs, so dout stays held during a stall.
- Output register: on accept, all out_* fields load and out_valid=1. Otherwise, if out_ready or flush, out_valid=0 and the fields hold.
- Scoreboard set/clear:
  - Accept with out_wr=1 sets sb[rd].
  - wb_we & wb_wa!=0 clears sb[wb_wa].
  - If the same index is set and cleared in one cycle, set wins.
  - hz is computed from the registered sb only. A writeback of rs in cycle N therefore permits issue in N+1, because the register file returns the old value on a same-edge write/read.
- Flush:
  - Drops out_valid.
  - If out_valid & out_wr, clears sb[out_rd] unless a same-cycle set targets that index.
  - No accept happens in the flush cycle.
  - Instructions already past decode are handled downstream.
- Immediate formats, all sign-extended from instr[31]:
  - I: loads, OP-IMM, JALR
  - S: stores
  - B: branches, bit0=0
  - U: LUI, AUIPC, low 12 bits=0
  - J: JAL, bit0=0
  - Others: imm=0.
- Illegal instructions: an unrecognised opcode or instr[1:0]!=2'b11 sets out_illegal=1 with out_wr=0 and does not read registers.

Test Plan:
- Reset mid-stream: out_valid=1 and sb[5]=1, assert resetn low -> out_valid=0 immediately, sb=0; the first instruction after release issues with no stall.
- Back-to-back ALU: addi x1,x0,5 then add x2,x1,x1 with no writeback -> second held (in_ready=0, rf_re1=0) until wb_we with wb_wa=1, then issues the following cycle with rf_ra1=rf_ra2=1.
- Same-cycle writeback: sb[3]=1 and wb_wa=3 in cycle N while "add x4,x3,x0" waits -> accept in N+1, not N.
- Output stall: out_ready=0 for 3 cycles after issue of "sub x6,x7,x8" -> out_valid stays 1, rf_re1/rf_re2=0, out fields stable, in_ready=0; accept resumes the cycle out_ready=1.
- Immediate decode: lui x5,0xABCDE -> out_imm=0xABCDE000. sw with offset -4 -> out_imm=0xFFFFFFFC. beq with offset -8 -> out_imm=0xFFFFFFF8.
- Flush: presented "addi x9,x0,1" and flush=1 -> out_valid=0 next cycle and sb[9]=0. An opcode of 7'b0000000 produces out_illegal=1 and out_wr=0.
